// File: rtl/alu_op_sequencer_if.sv
// Command/response bundle between a host and the ALU op sequencer.
interface alu_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_op;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_imm;
    logic        cmd_use_imm;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic        err;

    modport master (
        output cmd_valid, cmd_op, cmd_reg, cmd_imm, cmd_use_imm,
        input  cmd_ready, rsp_valid, rsp_result, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_reg, cmd_imm, cmd_use_imm,
        output cmd_ready, rsp_valid, rsp_result, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command front-end for the 8-bit calculator ALU: accepts one opcode per handshake, drives the
// external combinational ALU, owns the accumulator and {Z,N,C,O} flags, and iterates single ALU
// steps for power-n and shift-by-n.
module alu_op_sequencer #(
    parameter int unsigned SHIFT_CAP = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   cmd,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [7:0]          alu_c,
    output logic [5:0]          alu_opcode,
    input  logic [15:0]         alu_result,
    input  logic                alu_z,
    input  logic                alu_n,
    input  logic                alu_cy,
    input  logic                alu_o,
    output logic [7:0]          acc,
    output logic [3:0]          flags,
    output logic                busy
);

    localparam logic [5:0] OpFirst = 6'b001001;
    localparam logic [5:0] OpLast  = 6'b011110;
    localparam logic [5:0] OpLsr   = 6'b001011;
    localparam logic [5:0] OpLsl   = 6'b001100;
    localparam logic [5:0] OpMul   = 6'b010000;
    localparam logic [5:0] OpDiv   = 6'b010001;
    localparam logic [5:0] OpMod   = 6'b010010;
    localparam logic [5:0] OpCmp   = 6'b010111;
    localparam logic [5:0] OpTst   = 6'b011000;
    localparam logic [5:0] OpPown  = 6'b011101;
    localparam logic [7:0] ShiftCapW = 8'(SHIFT_CAP);

    typedef enum logic [1:0] {StIdle, StExec, StIter, StDone} state_e;

    state_e      state_q;
    logic [5:0]  op_q;
    logic [7:0]  reg_q;
    logic [7:0]  op2_q;
    logic [7:0]  work_q;
    logic [7:0]  count_q;
    logic        carry_q;
    logic [7:0]  acc_q;
    logic [3:0]  flags_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_result_q;
    logic        err_q;

    logic [7:0]  op2_in;
    logic        bad_in;
    logic        pown_in;
    logic        shift_in;
    logic [7:0]  shift_n;
    logic        pown_q;
    logic        step_c;
    logic [7:0]  step_w;

    // Decode the incoming command against the current accumulator.
    always_comb begin
        op2_in   = cmd.cmd_use_imm ? cmd.cmd_imm : acc_q;
        bad_in   = (cmd.cmd_op < OpFirst) || (cmd.cmd_op > OpLast) ||
                   (((cmd.cmd_op == OpDiv) || (cmd.cmd_op == OpMod)) && (op2_in == 8'h00));
        pown_in  = (cmd.cmd_op == OpPown);
        shift_in = (cmd.cmd_op == OpLsl) || (cmd.cmd_op == OpLsr);
        shift_n  = (32'(op2_in) >= SHIFT_CAP) ? ShiftCapW : op2_in;
    end

    // One iteration step: new work value and the carry it would commit if it were the last step.
    always_comb begin
        pown_q = (op_q == OpPown);
        step_w = alu_result[7:0];
        step_c = pown_q ? (carry_q | (alu_result[15:8] != 8'h00)) : alu_cy;
    end

    // Sequencer FSM with all state and response outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= 6'h00;
            reg_q        <= 8'h00;
            op2_q        <= 8'h00;
            work_q       <= 8'h00;
            count_q      <= 8'h00;
            carry_q      <= 1'b0;
            acc_q        <= 8'h00;
            flags_q      <= 4'h0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rsp_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                    if (cmd.cmd_valid) begin
                        op_q    <= cmd.cmd_op;
                        reg_q   <= cmd.cmd_reg;
                        op2_q   <= op2_in;
                        carry_q <= 1'b0;
                        if (bad_in) begin
                            err_q        <= 1'b1;
                            rsp_result_q <= 16'h0000;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= StDone;
                        end else if (pown_in) begin
                            if (op2_in == 8'h00) begin
                                // x^0 = 1 without touching the ALU.
                                acc_q        <= 8'h01;
                                rsp_result_q <= 16'h0001;
                                flags_q      <= 4'b0000;
                                rsp_valid_q  <= 1'b1;
                                state_q      <= StDone;
                            end else begin
                                work_q  <= 8'h01;
                                count_q <= op2_in;
                                state_q <= StIter;
                            end
                        end else if (shift_in) begin
                            if (shift_n == 8'h00) begin
                                acc_q        <= cmd.cmd_reg;
                                rsp_result_q <= {8'h00, cmd.cmd_reg};
                                flags_q      <= {cmd.cmd_reg == 8'h00, 3'b000};
                                rsp_valid_q  <= 1'b1;
                                state_q      <= StDone;
                            end else begin
                                work_q  <= cmd.cmd_reg;
                                count_q <= shift_n;
                                state_q <= StIter;
                            end
                        end else begin
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    rsp_result_q <= alu_result;
                    flags_q      <= {alu_z, alu_n, alu_cy, alu_o};
                    // Compare/test only report flags.
                    if ((op_q != OpCmp) && (op_q != OpTst)) begin
                        acc_q <= alu_result[7:0];
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StIter: begin
                    work_q  <= step_w;
                    count_q <= count_q - 8'd1;
                    carry_q <= step_c;
                    if (count_q <= 8'd1) begin
                        acc_q        <= step_w;
                        rsp_result_q <= {8'h00, step_w};
                        flags_q      <= {step_w == 8'h00, 1'b0, step_c, 1'b0};
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ALU operand/opcode steering; everything is zero outside EXEC/ITER.
    always_comb begin
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_c      = 8'h00;
        alu_opcode = 6'h00;
        if (state_q == StExec) begin
            alu_a      = reg_q;
            alu_b      = op2_q;
            alu_c      = op2_q;
            alu_opcode = op_q;
        end else if (state_q == StIter) begin
            if (pown_q) begin
                alu_a      = reg_q;
                alu_b      = work_q;
                alu_c      = work_q;
                alu_opcode = OpMul;
            end else begin
                alu_a      = work_q;
                alu_b      = 8'h01;
                alu_c      = 8'h01;
                alu_opcode = op_q;
            end
        end
    end

    // Status and response outputs.
    always_comb begin
        cmd.cmd_ready  = rst_n && (state_q == StIdle);
        cmd.rsp_valid  = rsp_valid_q;
        cmd.rsp_result = rsp_result_q;
        cmd.err        = err_q;
        busy           = (state_q != StIdle);
        acc            = acc_q;
        flags          = flags_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer with a behavioural ALU and command model.
module tb_alu_op_sequencer;

    localparam logic [5:0] OP_ADD  = 6'd9;
    localparam logic [5:0] OP_LSR  = 6'd11;
    localparam logic [5:0] OP_LSL  = 6'd12;
    localparam logic [5:0] OP_MOV  = 6'd13;  // this ALU model's MOV encoding
    localparam logic [5:0] OP_DIV  = 6'd17;
    localparam logic [5:0] OP_CMP  = 6'd23;
    localparam logic [5:0] OP_POWN = 6'd29;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  alu_a, alu_b, alu_c, acc;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_z, alu_n, alu_cy, alu_o, busy;
    logic [3:0]  flags;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SHIFT_CAP(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_cy     (alu_cy),
        .alu_o      (alu_o),
        .acc        (acc),
        .flags      (flags),
        .busy       (busy)
    );

    // Intended ALU semantics: returns {z, n, cy, o, result}.
    function automatic logic [19:0] alu_fn(input logic [5:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] r;
        logic        cy, o;
        r = 16'h0000;
        o = 1'b0;
        case (op)
            6'd9:  r = 16'(a) + 16'(b);
            6'd10: r = {8'h00, 8'(a - b)};
            6'd11: r = {8'h00, a >> 1};
            6'd12: r = {8'h00, 8'(a << 1)};
            6'd13: r = {8'h00, a};
            6'd14: r = {8'h00, 8'(8'h00 - a)};
            6'd15: r = {8'h00, a[3:0], a[7:4]};
            6'd16: r = 16'(a) * 16'(b);
            6'd17: r = (b == 8'h00) ? 16'hFFFF : 16'(a / b);
            6'd18: r = (b == 8'h00) ? 16'(a) : 16'(a % b);
            6'd19: r = {8'h00, a & b};
            6'd20: r = {8'h00, a | b};
            6'd21: r = {8'h00, a ^ b};
            6'd22: r = {8'h00, ~a};
            6'd23: r = {8'h00, 8'(a - b)};
            6'd24: r = {8'h00, a & b};
            6'd25: r = 16'(a) + 16'd1;
            6'd26: r = {8'h00, 8'(a - 8'd1)};
            6'd27: r = 16'(a) * 16'(a);
            6'd28: r = 16'(32'(a) * 32'(a) * 32'(a));
            6'd30: for (int i = 0; i < 16; i++) if (i * i <= int'(a)) r = 16'(i);
            default: r = 16'h0000;
        endcase
        case (op)
            6'd10, 6'd23: cy = (a < b);
            6'd11:        cy = a[0];
            6'd12:        cy = a[7];
            default:      cy = (r[15:8] != 8'h00);
        endcase
        if (op == 6'd9)                  o = (a[7] == b[7]) && (r[7] != a[7]);
        if (op == 6'd10 || op == 6'd23)  o = (a[7] != b[7]) && (r[7] != a[7]);
        return {r[7:0] == 8'h00, r[7], cy, o, r};
    endfunction

    always_comb {alu_z, alu_n, alu_cy, alu_o, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

    int          n_checks = 0;
    int          n_fail = 0;
    bit          started = 0;
    bit          pending = 0;
    int          cyc = 0;
    int          exp_lat;
    logic [15:0] exp_res;
    bit          exp_err;
    logic [7:0]  exp_acc, m_acc;
    logic [3:0]  exp_flags, m_flags;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference outcome of one command from the architectural rules.
    task automatic predict(input logic [5:0] op, input logic [7:0] rg, input logic [7:0] imm,
                           input logic ui);
        logic [7:0]  op2, w;
        logic [15:0] p;
        logic [19:0] f;
        int          n, k;
        bit          c;
        op2       = ui ? imm : m_acc;
        n         = int'(op2);
        exp_acc   = m_acc;
        exp_flags = m_flags;
        exp_err   = 1'b0;
        exp_res   = 16'h0000;
        if (op < 6'd9 || op > 6'd30 || ((op == 6'd17 || op == 6'd18) && op2 == 8'h00)) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (op == OP_POWN) begin
            w = 8'h01;
            c = 1'b0;
            for (int i = 0; i < n; i++) begin
                p = 16'(rg) * 16'(w);
                if (p > 16'd255) c = 1'b1;
                w = p[7:0];
            end
            exp_acc   = w;
            exp_res   = {8'h00, w};
            exp_flags = {w == 8'h00, 1'b0, c, 1'b0};
            exp_lat   = (n == 0) ? 1 : n + 1;
        end else if (op == OP_LSL || op == OP_LSR) begin
            k = (n > 8) ? 8 : n;
            w = rg;
            c = 1'b0;
            for (int i = 0; i < k; i++) begin
                if (op == OP_LSL) begin c = w[7]; w = w << 1; end
                else              begin c = w[0]; w = w >> 1; end
            end
            exp_acc   = w;
            exp_res   = {8'h00, w};
            exp_flags = {w == 8'h00, 1'b0, c, 1'b0};
            exp_lat   = (k == 0) ? 1 : k + 1;
        end else begin
            f         = alu_fn(op, rg, op2);
            exp_res   = f[15:0];
            exp_flags = f[19:16];
            if (op != OP_CMP && op != 6'd24) exp_acc = f[7:0];
            exp_lat   = 2;
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        bit exp_v;
        if (started) begin
            if (!rst_n) begin
                check("rsp_valid_in_reset", 32'(bus.rsp_valid), 32'(1'b0));
                check("ready_in_reset", 32'(bus.cmd_ready), 32'(1'b0));
            end else begin
                if (pending) cyc++;
                exp_v = pending && (cyc == exp_lat);
                check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
                check("busy", 32'(busy), 32'(pending));
                check("cmd_ready", 32'(bus.cmd_ready), 32'(!pending));
                if (exp_v) begin
                    check("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
                    check("err", 32'(bus.err), 32'(exp_err));
                    check("acc", 32'(acc), 32'(exp_acc));
                    check("flags", 32'(flags), 32'(exp_flags));
                    m_acc   = exp_acc;
                    m_flags = exp_flags;
                    pending = 1'b0;
                end else if (!pending) begin
                    check("idle_acc", 32'(acc), 32'(m_acc));
                    check("idle_flags", 32'(flags), 32'(m_flags));
                    check("idle_opcode", 32'(alu_opcode), 32'(6'h00));
                    check("idle_alu_a", 32'(alu_a), 32'(8'h00));
                end
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [7:0] rg, input logic [7:0] imm,
                        input logic ui, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        #1;
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("ready_wait", 32'(bus.cmd_ready), 32'(1'b1));
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_reg     = rg;
        bus.cmd_imm     = imm;
        bus.cmd_use_imm = ui;
        predict(op, rg, imm, ui);
        @(posedge clk);
        pending = 1'b1;
        cyc     = 0;
        #1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 6'($urandom);
        bus.cmd_reg     = 8'($urandom);
        bus.cmd_imm     = 8'($urandom);
        bus.cmd_use_imm = 1'($urandom);
    endtask

    // Leaves the caller in the response cycle, #1 after its falling edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (pending && lat < 1000) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (pending) begin
            check("done_timeout", 32'(pending), 32'(1'b0));
            pending = 1'b0;
        end
    endtask

    initial begin
        int          l;
        logic [5:0]  op;
        logic [7:0]  imm;
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 6'h00;
        bus.cmd_reg     = 8'h00;
        bus.cmd_imm     = 8'h00;
        bus.cmd_use_imm = 1'b0;
        m_acc           = 8'h00;
        m_flags         = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        check("reset_acc", 32'(acc), 32'(8'h00));
        check("reset_busy", 32'(busy), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with acc as operand after reset.
        send(OP_ADD, 8'd5, 8'hAA, 1'b0, 0);
        wait_done(l);
        check("t1_latency", 32'(l), 32'd2);
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'(1'b1));
        check("t1_result", 32'(bus.rsp_result), 32'h0005);
        check("t1_acc", 32'(acc), 32'h05);
        check("t1_flags", 32'(flags), 32'h0);

        send(OP_POWN, 8'd3, 8'd4, 1'b1, 0);
        wait_done(l);
        check("t2_latency", 32'(l), 32'd5);
        check("t2_acc", 32'(acc), 32'h51);
        check("t2_carry", 32'(flags[1]), 32'(1'b0));
        send(OP_POWN, 8'd2, 8'd9, 1'b1, 1);
        wait_done(l);
        check("t2b_acc", 32'(acc), 32'h00);
        check("t2b_zc", 32'({flags[3], flags[1]}), 32'(2'b11));

        send(OP_LSL, 8'h81, 8'd1, 1'b1, 0);
        wait_done(l);
        check("t3_acc", 32'(acc), 32'h02);
        check("t3_carry", 32'(flags[1]), 32'(1'b1));
        send(OP_LSR, 8'hF0, 8'd10, 1'b1, 0);
        wait_done(l);
        check("t3b_latency", 32'(l), 32'd9);
        check("t3b_acc", 32'(acc), 32'h00);
        check("t3b_zero", 32'(flags[3]), 32'(1'b1));

        // 0x87 + 0x80 = 0x107: acc 07, C and O set.
        send(OP_ADD, 8'h87, 8'h80, 1'b1, 0);
        wait_done(l);
        check("t4_setup_flags", 32'(flags), 32'(4'b0011));
        send(OP_DIV, 8'd10, 8'd0, 1'b1, 0);
        wait_done(l);
        check("t4_err", 32'(bus.err), 32'(1'b1));
        check("t4_result", 32'(bus.rsp_result), 32'h0000);
        check("t4_acc", 32'(acc), 32'h07);
        check("t4_flags", 32'(flags), 32'(4'b0011));
        send(6'b100001, 8'd1, 8'd1, 1'b1, 0);
        wait_done(l);
        check("t4b_err", 32'(bus.err), 32'(1'b1));

        send(OP_CMP, 8'd7, 8'd0, 1'b0, 0);
        wait_done(l);
        check("t5_flags", 32'(flags), 32'(4'b1000));
        check("t5_acc", 32'(acc), 32'h07);
        send(OP_MOV, 8'h80, 8'd0, 1'b1, 0);
        wait_done(l);
        check("t5b_acc", 32'(acc), 32'h80);

        // Reset during the third power iteration.
        send(OP_POWN, 8'd2, 8'd8, 1'b1, 0);
        l = 0;
        while (cyc < 3 && l < 20) begin
            @(negedge clk);
            #1;
            l++;
        end
        rst_n   = 1'b0;
        pending = 1'b0;
        @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 32'(1'b0));
        check("t6_acc", 32'(acc), 32'h00);
        check("t6_flags", 32'(flags), 32'h0);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'(1'b0));
        m_acc   = 8'h00;
        m_flags = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
            else                           op = 6'($urandom_range(9, 30));
            if (op == OP_POWN || op == OP_LSL || op == OP_LSR) imm = 8'($urandom_range(0, 12));
            else if ($urandom_range(0, 5) == 0)                 imm = 8'h00;
            else                                                imm = 8'($urandom);
            send(op, 8'($urandom), imm, 1'($urandom), $urandom_range(0, 2));
            wait_done(l);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
